// File: rtl/lcd_text_buffer_pkg.sv
// lcd_text_buffer_pkg: shared state encoding and host control codes for the LCD text buffer
package lcd_text_buffer_pkg;
   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
   localparam logic [7:0] CH_BS = 8'h08;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_FF = 8'h0C;
   localparam logic [7:0] CH_CR = 8'h0D;
   function automatic logic is_printable(input logic [7:0] c);
      return c >= 8'h20 && c <= 8'h7E;
   endfunction
endpackage

// File: rtl/lcd_text_ram.sv
// lcd_text_ram: character store with one write port and one registered read-first read port
module lcd_text_ram #(
   parameter int         DEPTH = 32,
   parameter int         AW    = 5,
   parameter logic [7:0] INIT  = 8'h20
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);
   logic [7:0] mem [DEPTH];
   // array write, kept free of reset so it maps onto block RAM
   always_ff @(posedge sys_clk)
      if (we) mem[waddr] <= wdata;
   // read register samples the array before this edge's write lands, and holds when idle
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) rdata <= INIT;
      else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: host character stream into a ROWSxCOLS text RAM read by an LCD driver
module lcd_text_buffer
   import lcd_text_buffer_pkg::*;
#(
   parameter  int         COLS  = 16,
   parameter  int         ROWS  = 2,
   parameter  logic [7:0] BLANK = 8'h20,
   localparam int         DEPTH = COLS * ROWS,
   localparam int         AW    = $clog2(DEPTH)
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          wr_valid,
   input  logic [7:0]    wr_data,
   output logic          wr_ready,
   input  logic          rd,
   input  logic [AW-1:0] addr,
   output logic [7:0]    character,
   output logic [AW-1:0] cursor,
   output logic          dirty,
   input  logic          refresh_done
);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   state_t        state, state_nxt;
   logic [AW-1:0] sweep, sweep_nxt, cursor_nxt, row_start, next_row, waddr;
   logic [7:0]    wdata;
   logic          xfer, print, last, we;
   int            row;
   // row arithmetic for line feed and carriage return
   always_comb begin
      row       = int'(cursor) / COLS;
      row_start = AW'(row * COLS);
      next_row  = (row == ROWS - 1) ? '0 : AW'((row + 1) * COLS);
   end
   // next state, cursor movement and RAM write selection
   always_comb begin
      state_nxt  = state;
      sweep_nxt  = sweep;
      cursor_nxt = cursor;
      wr_ready   = (state == ST_IDLE);
      xfer       = wr_valid && wr_ready;
      print      = xfer && is_printable(wr_data);
      last       = (state == ST_CLEAR) && (sweep == LAST);
      if (state == ST_CLEAR) begin
         sweep_nxt  = last ? '0 : sweep + 1'b1;
         state_nxt  = last ? ST_IDLE : ST_CLEAR;
         cursor_nxt = last ? '0 : cursor;
      end else if (xfer) begin
         state_nxt  = (wr_data == CH_FF) ? ST_CLEAR : ST_IDLE;
         cursor_nxt = print             ? ((cursor == LAST) ? '0 : cursor + 1'b1) :
                      wr_data == CH_LF  ? next_row :
                      wr_data == CH_CR  ? row_start :
                      wr_data == CH_BS  ? ((cursor == '0) ? '0 : cursor - 1'b1) :
                                          cursor;
      end
      we    = (state == ST_CLEAR) || print;
      waddr = (state == ST_CLEAR) ? sweep : cursor;
      wdata = (state == ST_CLEAR) ? BLANK : wr_data;
   end
   // control registers; a new change outranks a simultaneous refresh acknowledge
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         state  <= ST_CLEAR;
         sweep  <= '0;
         cursor <= '0;
         dirty  <= 1'b0;
      end else begin
         state  <= state_nxt;
         sweep  <= sweep_nxt;
         cursor <= cursor_nxt;
         dirty  <= print || last || (dirty && !refresh_done);
      end
   lcd_text_ram #(.DEPTH(DEPTH), .AW(AW), .INIT(BLANK)) u_ram (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .re        (rd),
      .raddr     (addr),
      .rdata     (character)
   );
endmodule

// File: tb/tb_lcd_text_buffer.sv
// tb_lcd_text_buffer: directed vector bench for the LCD text buffer
module tb_lcd_text_buffer;
   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_ready;
   logic       rd = 1'b0;
   logic [4:0] addr = 5'd0;
   logic [7:0] character;
   logic [4:0] cursor;
   logic       dirty;
   logic       refresh_done = 1'b0;
   int         n_checks = 0;
   int         n_fail = 0;

   typedef struct {
      logic       valid;
      logic [7:0] data;
      logic       refresh;
      logic [4:0] cur;
      logic       dirty;
   } vec_t;
   typedef struct {
      logic [4:0] a;
      logic [7:0] d;
   } mem_t;
   vec_t vt[26];
   mem_t mt[14];

   lcd_text_buffer dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .wr_valid     (wr_valid),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .rd           (rd),
      .addr         (addr),
      .character    (character),
      .cursor       (cursor),
      .dirty        (dirty),
      .refresh_done (refresh_done)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input logic v, input logic [7:0] d, input logic r);
      wr_valid = v;
      wr_data = d;
      refresh_done = r;
      @(posedge sys_clk);
      #1;
      wr_valid = 1'b0;
      refresh_done = 1'b0;
   endtask

   task automatic wr(input logic [7:0] d);
      apply(1'b1, d, 1'b0);
   endtask

   task automatic rd_chk(input string name, input logic [4:0] a, input logic [7:0] exp);
      rd = 1'b1;
      addr = a;
      @(posedge sys_clk);
      #1;
      rd = 1'b0;
      check(name, character, exp);
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!wr_ready && n < 200) begin
         @(posedge sys_clk);
         #1;
         n++;
      end
   endtask

   initial begin
      int n;
      vt[0]  = '{1'b1, 8'h48, 1'b0, 5'd1,  1'b1};
      vt[1]  = '{1'b1, 8'h49, 1'b0, 5'd2,  1'b1};
      vt[2]  = '{1'b0, 8'h00, 1'b1, 5'd2,  1'b0};
      vt[3]  = '{1'b1, 8'h43, 1'b0, 5'd3,  1'b1};
      vt[4]  = '{1'b1, 8'h44, 1'b0, 5'd4,  1'b1};
      vt[5]  = '{1'b1, 8'h45, 1'b0, 5'd5,  1'b1};
      vt[6]  = '{1'b0, 8'h00, 1'b1, 5'd5,  1'b0};
      vt[7]  = '{1'b1, 8'h0A, 1'b0, 5'd16, 1'b0};
      vt[8]  = '{1'b1, 8'h41, 1'b0, 5'd17, 1'b1};
      vt[9]  = '{1'b1, 8'h42, 1'b1, 5'd18, 1'b1};
      vt[10] = '{1'b0, 8'h00, 1'b1, 5'd18, 1'b0};
      vt[11] = '{1'b1, 8'h43, 1'b0, 5'd19, 1'b1};
      vt[12] = '{1'b1, 8'h44, 1'b0, 5'd20, 1'b1};
      vt[13] = '{1'b0, 8'h00, 1'b1, 5'd20, 1'b0};
      vt[14] = '{1'b1, 8'h0A, 1'b0, 5'd0,  1'b0};
      vt[15] = '{1'b1, 8'h0D, 1'b0, 5'd0,  1'b0};
      vt[16] = '{1'b1, 8'h08, 1'b0, 5'd0,  1'b0};
      vt[17] = '{1'b1, 8'h0A, 1'b0, 5'd16, 1'b0};
      vt[18] = '{1'b1, 8'h7E, 1'b0, 5'd17, 1'b1};
      vt[19] = '{1'b1, 8'h0D, 1'b0, 5'd16, 1'b1};
      vt[20] = '{1'b1, 8'h08, 1'b0, 5'd15, 1'b1};
      vt[21] = '{1'b1, 8'h01, 1'b0, 5'd15, 1'b1};
      vt[22] = '{1'b1, 8'h7F, 1'b0, 5'd15, 1'b1};
      vt[23] = '{1'b1, 8'h1F, 1'b0, 5'd15, 1'b1};
      vt[24] = '{1'b0, 8'h00, 1'b1, 5'd15, 1'b0};
      vt[25] = '{1'b1, 8'h5A, 1'b0, 5'd16, 1'b1};
      mt[0]  = '{5'd0,  8'h48};
      mt[1]  = '{5'd1,  8'h49};
      mt[2]  = '{5'd2,  8'h43};
      mt[3]  = '{5'd3,  8'h44};
      mt[4]  = '{5'd4,  8'h45};
      mt[5]  = '{5'd5,  8'h20};
      mt[6]  = '{5'd14, 8'h20};
      mt[7]  = '{5'd15, 8'h5A};
      mt[8]  = '{5'd16, 8'h7E};
      mt[9]  = '{5'd17, 8'h42};
      mt[10] = '{5'd18, 8'h43};
      mt[11] = '{5'd19, 8'h44};
      mt[12] = '{5'd20, 8'h20};
      mt[13] = '{5'd31, 8'h20};

      // reset state and power-up sweep
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_wr_ready", wr_ready, 0);
      check("rst_cursor", cursor, 0);
      check("rst_dirty", dirty, 0);
      check("rst_character", character, 8'h20);
      sys_rst_n = 1'b1;
      wait_ready(n);
      check("init_sweep_cycles", n, 32);
      check("init_dirty", dirty, 1);
      check("init_cursor", cursor, 0);
      for (int i = 0; i < 32; i++) rd_chk($sformatf("init_blank[%0d]", i), 5'(i), 8'h20);

      // table-driven write stream
      for (int i = 0; i < 26; i++) begin
         apply(vt[i].valid, vt[i].data, vt[i].refresh);
         check($sformatf("vec%0d_cursor", i), cursor, vt[i].cur);
         check($sformatf("vec%0d_dirty", i), dirty, vt[i].dirty);
         if (i == 8) rd_chk("lf_then_A_mem16", 5'd16, 8'h41);
      end
      for (int i = 0; i < 14; i++) rd_chk($sformatf("mem[%0d]", mt[i].a), mt[i].a, mt[i].d);

      // read and write of the same address in one cycle returns old data
      wr(8'h0A);
      wr(8'h48);
      wr(8'h49);
      wr(8'h43);
      check("pre_collide_cursor", cursor, 3);
      wr_valid = 1'b1;
      wr_data = 8'h5A;
      rd = 1'b1;
      addr = 5'd3;
      @(posedge sys_clk);
      #1;
      wr_valid = 1'b0;
      rd = 1'b0;
      check("collide_old_data", character, 8'h44);
      check("collide_cursor", cursor, 4);
      rd_chk("collide_new_data", 5'd3, 8'h5A);
      addr = 5'd0;
      @(posedge sys_clk);
      #1;
      check("read_hold", character, 8'h5A);

      // cursor wrap over a full screen, overwrite, backspace saturation
      wr(8'h0A);
      wr(8'h0A);
      check("wrap_start_cursor", cursor, 0);
      for (int i = 0; i < 32; i++) wr(8'h61 + 8'(i % 26));
      check("wrap_cursor", cursor, 0);
      rd_chk("wrap_mem31", 5'd31, 8'h66);
      wr(8'h21);
      check("overwrite_cursor", cursor, 1);
      rd_chk("overwrite_mem0", 5'd0, 8'h21);
      wr(8'h08);
      check("bs_cursor", cursor, 0);
      wr(8'h08);
      check("bs_saturate", cursor, 0);

      // form feed, reads during the sweep, reset mid-sweep
      wr(8'h21);
      wr(8'h0C);
      check("ff_wr_ready", wr_ready, 0);
      check("ff_cursor_held", cursor, 1);
      rd_chk("clear_read_unswept", 5'd5, 8'h66);
      rd_chk("clear_read_swept", 5'd0, 8'h20);
      repeat (8) @(posedge sys_clk);
      #1;
      check("mid_sweep_wr_ready", wr_ready, 0);
      sys_rst_n = 1'b0;
      #1;
      check("abort_wr_ready", wr_ready, 0);
      check("abort_cursor", cursor, 0);
      check("abort_dirty", dirty, 0);
      check("abort_character", character, 8'h20);
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      wait_ready(n);
      check("restart_sweep_cycles", n, 32);
      check("restart_cursor", cursor, 0);
      check("restart_dirty", dirty, 1);
      rd_chk("restart_mem0", 5'd0, 8'h20);
      rd_chk("restart_mem10", 5'd10, 8'h20);
      rd_chk("restart_mem20", 5'd20, 8'h20);
      rd_chk("restart_mem31", 5'd31, 8'h20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
